audio_play_gain: RTL

- Playback-path conditioning stage between the Xillybus audio write stream and the playback FIFO of the I2S audio interface.
- Takes stereo words (left [31:16], right [15:0], signed 16-bit) and applies a per-channel Q2.8 gain with rounding and saturation.
- Provides a click-free soft-mute ramp and per-channel peak meters.
- Uses the Xillybus wren/full handshake on both sides, so it drops in unchanged where the FIFO write port was connected.

---
 rtl/audio_play_gain.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/audio_play_gain.sv
// Playback conditioning stage: per-channel Q2.8 gain with rounding and saturation,
// a soft-mute/gain ramp and windowed peak meters, using the wren/full handshake on both sides.
module audio_play_gain #(
  parameter int GAIN_W      = 10,
  parameter int RAMP_STEP   = 16,
  parameter int PEAK_WINDOW = 4800
) (
  input  logic              bus_clk,
  input  logic              quiesce,
  input  logic              in_wren,
  input  logic [31:0]       in_data,
  output logic              in_full,
  output logic              out_wren,
  output logic [31:0]       out_data,
  input  logic              out_full,
  input  logic [GAIN_W-1:0] gain_left,
  input  logic [GAIN_W-1:0] gain_right,
  input  logic              mute,
  output logic [14:0]       peak_left,
  output logic [14:0]       peak_right,
  output logic              overrun
);

  localparam int PW = 16 + GAIN_W + 1;
  localparam logic signed [GAIN_W+1:0] STEP_D  = (GAIN_W+2)'(RAMP_STEP);
  localparam logic [GAIN_W-1:0]        STEP_G  = GAIN_W'(RAMP_STEP);
  localparam logic signed [PW-1:0]     ROUND_C = PW'(128);
  localparam logic signed [PW-1:0]     SAT_MAX = PW'(32767);
  localparam logic signed [PW-1:0]     SAT_MIN = PW'(-32768);
  localparam logic [15:0]              WIN_LAST = 16'(PEAK_WINDOW - 1);

  function automatic logic [GAIN_W-1:0] ramp_to(input logic [GAIN_W-1:0] eff,
                                                input logic [GAIN_W-1:0] target);
    logic signed [GAIN_W+1:0] diff;
    diff = $signed({2'b00, target}) - $signed({2'b00, eff});
    if (diff > STEP_D)       ramp_to = eff + STEP_G;
    else if (diff < -STEP_D) ramp_to = eff - STEP_G;
    else                     ramp_to = target;
  endfunction

  function automatic logic signed [PW-1:0] scale(input logic [15:0] s,
                                                 input logic [GAIN_W-1:0] g);
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    a = PW'($signed(s));
    b = PW'($signed({1'b0, g}));
    scale = a * b;
  endfunction

  // Round half up in Q2.8, then clamp into the 16-bit sample range.
  function automatic logic [15:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + ROUND_C) >>> 8;
    if (r > SAT_MAX)      round_sat = 16'h7FFF;
    else if (r < SAT_MIN) round_sat = 16'h8000;
    else                  round_sat = r[15:0];
  endfunction

  function automatic logic [14:0] mag(input logic [15:0] s);
    logic [15:0] n;
    n = -s;
    if (s == 16'h8000) mag = 15'h7FFF;
    else if (s[15])    mag = n[14:0];
    else               mag = s[14:0];
  endfunction

  logic                    s1_valid;
  logic                    s2_valid;
  logic signed [PW-1:0]    s1_prod_l;
  logic signed [PW-1:0]    s1_prod_r;
  logic [GAIN_W-1:0]       eff_l;
  logic [GAIN_W-1:0]       eff_r;
  logic [GAIN_W-1:0]       tgt_l;
  logic [GAIN_W-1:0]       tgt_r;
  logic                    s1_load;
  logic                    s2_load;
  logic                    accept;
  logic [15:0]             win_cnt;
  logic [14:0]             acc_l;
  logic [14:0]             acc_r;
  logic [14:0]             mag_l;
  logic [14:0]             mag_r;
  logic [14:0]             hi_l;
  logic [14:0]             hi_r;

  assign out_wren = s2_valid & ~out_full;
  assign s2_load  = s1_valid & (~s2_valid | out_wren);
  assign s1_load  = ~s1_valid | s2_load;
  assign in_full  = ~s1_load;
  assign accept   = in_wren & s1_load;

  always_comb begin
    tgt_l = mute ? '0 : gain_left;
    tgt_r = mute ? '0 : gain_right;
    mag_l = mag(out_data[31:16]);
    mag_r = mag(out_data[15:0]);
    hi_l  = (mag_l > acc_l) ? mag_l : acc_l;
    hi_r  = (mag_r > acc_r) ? mag_r : acc_r;
  end

  // The product uses the gain held before this word's ramp update.
  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      s1_valid  <= 1'b0;
      s1_prod_l <= '0;
      s1_prod_r <= '0;
      eff_l     <= '0;
      eff_r     <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod_l <= scale(in_data[31:16], eff_l);
        s1_prod_r <= scale(in_data[15:0], eff_r);
        eff_l     <= ramp_to(eff_l, tgt_l);
        eff_r     <= ramp_to(eff_r, tgt_r);
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      overrun  <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        out_data <= {round_sat(s1_prod_l), round_sat(s1_prod_r)};
      end else if (out_wren) begin
        s2_valid <= 1'b0;
      end
      if (in_wren & in_full) overrun <= 1'b1;
    end
  end

  // The publishing word itself still competes with the accumulated maximum.
  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      win_cnt    <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      peak_left  <= '0;
      peak_right <= '0;
    end else if (out_wren) begin
      if (win_cnt == WIN_LAST) begin
        peak_left  <= hi_l;
        peak_right <= hi_r;
        acc_l      <= '0;
        acc_r      <= '0;
        win_cnt    <= '0;
      end else begin
        acc_l   <= hi_l;
        acc_r   <= hi_r;
        win_cnt <= win_cnt + 16'd1;
      end
    end
  end

endmodule
